// File: rtl/rx_pkg.sv
// Shared helpers for the receiver_array slice.
// Optional build macro RX_SYNC_EN (see rx_channel) adds a 2-flop input synchroniser.
package rx_pkg;

  // Width helper that never returns zero, so single-entry params still get a 1-bit bus.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/rx_channel.sv
// One 2-phase receive channel: request edge detection, ack toggle and token counter.
// With RX_SYNC_EN defined, inR is passed through a 2-flop synchroniser first.
module rx_channel
  import rx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inR,
  input  logic pop,
  output logic inA,
  output logic notEmpty,
  output logic full
);

  localparam int CNT_W = clog2_min1(DEPTH + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             inA_r;
  logic             inRSync_s;
  logic             atDepth_s;
  logic             accept_s;

`ifdef RX_SYNC_EN
  logic meta_r;
  logic sync_r;

  // Two-stage synchroniser for requests arriving from unclocked stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= inR;
      sync_r <= meta_r;
    end
  end

  assign inRSync_s = sync_r;
`else
  assign inRSync_s = inR;
`endif

  // A pop in the same cycle frees the slot, so a full channel can still accept.
  assign atDepth_s = (cnt_r == CNT_W'(DEPTH));
  assign accept_s  = (inRSync_s != inA_r) & (~atDepth_s | pop);

  // Ack toggle and token count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inA_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      inA_r <= inA_r ^ accept_s;
      if (accept_s && !pop) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else if (pop && !accept_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign inA      = inA_r;
  assign notEmpty = (cnt_r != '0);
  assign full     = atDepth_s;

endmodule

// File: rtl/receiver_array.sv
// N-channel 2-phase receiver with per-channel token buffers and a round-robin output arbiter.
// Build macro RX_SYNC_EN enables per-channel input synchronisers (3-cycle ack latency).
module receiver_array
  import rx_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 2,
  localparam int IDX_W = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] inR,
  output logic [NUM_CH-1:0] inA,
  input  logic              i_freeNext,
  output logic              o_valid,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_grant_idx,
  output logic [NUM_CH-1:0] o_full
);

  logic [NUM_CH-1:0] notEmpty_s;
  logic [NUM_CH-1:0] pop_s;
  logic [IDX_W-1:0]  rrPtr_r;
  logic [IDX_W-1:0]  grantIdx_s;
  logic              found_s;
  logic [IDX_W:0]    cand_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rx_channel #(.DEPTH(DEPTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .inR      (inR[c]),
      .pop      (pop_s[c]),
      .inA      (inA[c]),
      .notEmpty (notEmpty_s[c]),
      .full     (o_full[c])
    );
  end

  // Round-robin search starting at rrPtr_r, wrapping modulo NUM_CH.
  always_comb begin
    found_s    = 1'b0;
    grantIdx_s = '0;
    cand_s     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_s = {1'b0, rrPtr_r} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(NUM_CH)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_CH);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && notEmpty_s[cand_s[IDX_W-1:0]]) begin
        found_s    = 1'b1;
        grantIdx_s = cand_s[IDX_W-1:0];
      end else begin
        found_s    = found_s;
      end
    end
  end

  assign o_valid     = found_s;
  assign o_grant_idx = found_s ? grantIdx_s : '0;
  assign o_grant     = found_s ? (NUM_CH'(1) << grantIdx_s) : '0;
  assign pop_s       = o_grant & {NUM_CH{i_freeNext}};

  // Pointer moves just past the consumed channel; holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_r <= '0;
    end else if (i_freeNext && found_s) begin
      if (grantIdx_s == IDX_W'(NUM_CH - 1)) begin
        rrPtr_r <= '0;
      end else begin
        rrPtr_r <= grantIdx_s + IDX_W'(1);
      end
    end else begin
      rrPtr_r <= rrPtr_r;
    end
  end

endmodule

// File: tb/tb_receiver_array.sv
// Directed bench for receiver_array (NUM_CH=4, DEPTH=2, default build without RX_SYNC_EN).
module tb_receiver_array;

  logic       clk;
  logic       rst_n;
  logic [3:0] inR;
  logic [3:0] inA;
  logic       freeNext;
  logic       valid;
  logic [3:0] grant;
  logic [1:0] grantIdx;
  logic [3:0] full;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] inR;
    logic       free;
    logic [3:0] expA;
    logic       expV;
    logic [3:0] expG;
    logic [1:0] expIdx;
    logic [3:0] expFull;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  receiver_array #(.NUM_CH(4), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inR         (inR),
    .inA         (inA),
    .i_freeNext  (freeNext),
    .o_valid     (valid),
    .o_grant     (grant),
    .o_grant_idx (grantIdx),
    .o_full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //            inR     fr    inA     v     grant   idx    full
    // all four channels take one token, then drained round-robin
    vecs[0]  = '{4'b1111, 1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0000};
    vecs[1]  = '{4'b1111, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 4'b0000};
    vecs[2]  = '{4'b1111, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 4'b0000};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 4'b0000};
    vecs[4]  = '{4'b1111, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 4'b0000};
    // single token on ch2, held, consumed, then free while empty
    vecs[5]  = '{4'b1011, 1'b0, 4'b1011, 1'b1, 4'b0100, 2'd2, 4'b0000};
    vecs[6]  = '{4'b1011, 1'b0, 4'b1011, 1'b1, 4'b0100, 2'd2, 4'b0000};
    vecs[7]  = '{4'b1011, 1'b1, 4'b1011, 1'b0, 4'b0000, 2'd0, 4'b0000};
    vecs[8]  = '{4'b1011, 1'b1, 4'b1011, 1'b0, 4'b0000, 2'd0, 4'b0000};
    // rr_ptr=3, tokens on ch1 and ch3: ch3 first, then ch1
    vecs[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b1000, 2'd3, 4'b0000};
    vecs[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0010, 2'd1, 4'b0000};
    vecs[11] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0, 4'b0000};
    // fill ch0 to DEPTH, third token held until a pop passes it through
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000};
    vecs[13] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001};
    vecs[14] = '{4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001};
    vecs[15] = '{4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0001};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000};

    // Reset held with requests already toggled
    rst_n    = 1'b0;
    inR      = 4'b1111;
    freeNext = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inA",   32'(inA),   32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_full",  32'(full),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      inR      = vecs[i].inR;
      freeNext = vecs[i].free;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_inA", i),  32'(inA),      32'(vecs[i].expA));
      check($sformatf("v%0d_valid", i), 32'(valid),    32'(vecs[i].expV));
      check($sformatf("v%0d_grant", i), 32'(grant),    32'(vecs[i].expG));
      check($sformatf("v%0d_idx", i),   32'(grantIdx), 32'(vecs[i].expIdx));
      check($sformatf("v%0d_full", i),  32'(full),     32'(vecs[i].expFull));
      @(negedge clk);
    end

    // Mid-cycle asynchronous reset with two tokens buffered (rr_ptr=1)
    inR      = 4'b0011;
    freeNext = 1'b0;
    @(posedge clk);
    #1;
    check("t6_pre_inA",   32'(inA),   32'h3);
    check("t6_pre_grant", 32'(grant), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(valid), 32'h0);
    check("t6_async_grant", 32'(grant), 32'h0);
    check("t6_async_inA",   32'(inA),   32'h0);
    inR = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_post_valid", 32'(valid), 32'h0);
    check("t6_post_inA",   32'(inA),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so a stuck run still ends with a report
  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
